// File: rtl/mmio_launch_sequencer.sv
// mmio_launch_sequencer: one launch programs start_addr, verifies it, pulses reset, unhalts, issues go, polls done, halts; ports clk/rst_n, launch/addr/timeout/abort in, busy+status pulses out, mmio write/read channel
module mmio_launch_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter int TIMEOUT_WIDTH = 32,
  parameter int POLL_INTERVAL = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  input  logic [ADDR_WIDTH-1:0] launch_addr,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  logic abort,
  output logic busy,
  output logic complete,
  output logic timed_out,
  output logic readback_err,
  output logic aborted,
  output logic mmio_wr_en,
  output logic [15:0] mmio_wr_addr,
  output logic [63:0] mmio_wr_data,
  output logic mmio_rd_en,
  output logic [15:0] mmio_rd_addr,
  input  logic [63:0] mmio_rd_data
);
  localparam logic [3:0] IDLE = 4'd0, WR_ADDR = 4'd1, RD_ADDR = 4'd2, CHK_ADDR = 4'd3,
    WR_RST1 = 4'd4, WR_RST0 = 4'd5, WR_UNHALT = 4'd6, WR_GO = 4'd7, POLL_RD = 4'd8,
    POLL_CHK = 4'd9, POLL_WAIT = 4'd10, HALT = 4'd11;
  localparam logic [1:0] C_DONE = 2'd0, C_TMO = 2'd1, C_ABT = 2'd2;
  logic [3:0] state, nxt;
  logic [1:0] cause, ncause;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, pcnt;
  logic [31:0] wcnt;
  logic polling;
  assign polling = state == POLL_RD || state == POLL_CHK || state == POLL_WAIT;
  always_comb begin
    nxt = state;
    ncause = cause;
    case (state)
      IDLE: nxt = launch ? WR_ADDR : IDLE;
      WR_ADDR: nxt = RD_ADDR;
      RD_ADDR: nxt = CHK_ADDR;
      CHK_ADDR: nxt = mmio_rd_data[ADDR_WIDTH-1:0] == addr_q ? WR_RST1 : IDLE;
      WR_RST1: nxt = WR_RST0;
      WR_RST0: nxt = WR_UNHALT;
      WR_UNHALT: nxt = WR_GO;
      WR_GO: nxt = POLL_RD;
      POLL_RD: nxt = POLL_CHK;
      POLL_CHK: begin
        nxt = mmio_rd_data[0] || (tmo_q != '0 && pcnt >= tmo_q) ? HALT :
              POLL_INTERVAL == 0 ? POLL_RD : POLL_WAIT;
        ncause = mmio_rd_data[0] ? C_DONE : C_TMO;
      end
      POLL_WAIT: nxt = wcnt == 32'(POLL_INTERVAL - 1) ? POLL_RD : POLL_WAIT;
      HALT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE && state != HALT) begin
      nxt = HALT;
      ncause = C_ABT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cause <= C_DONE;
      busy <= 1'b0;
      complete <= 1'b0;
      timed_out <= 1'b0;
      aborted <= 1'b0;
      readback_err <= 1'b0;
      addr_q <= '0;
      tmo_q <= '0;
      pcnt <= '0;
      wcnt <= '0;
    end else begin
      state <= nxt;
      cause <= ncause;
      busy <= nxt != IDLE;
      complete <= state == HALT && cause == C_DONE;
      timed_out <= state == HALT && cause == C_TMO;
      aborted <= state == HALT && cause == C_ABT;
      readback_err <= state == CHK_ADDR && nxt == IDLE;
      if (state == IDLE && launch) begin
        addr_q <= launch_addr;
        tmo_q <= timeout_cycles;
      end
      pcnt <= state == WR_GO ? '0 : polling && pcnt != '1 ? pcnt + 1'b1 : pcnt;
      wcnt <= state == POLL_WAIT ? wcnt + 32'd1 : 32'd0;
    end
  end
  // strobes decode straight from the state register so an async reset drops them at once
  assign mmio_wr_en = state == WR_ADDR || state == WR_RST1 || state == WR_RST0 ||
                      state == WR_UNHALT || state == WR_GO || state == HALT;
  assign mmio_wr_addr = state == WR_ADDR ? 16'h0052 :
                        state == WR_RST1 || state == WR_RST0 ? 16'h0054 :
                        state == WR_UNHALT || state == HALT ? 16'h0056 :
                        state == WR_GO ? 16'h0050 : 16'h0000;
  assign mmio_wr_data = state == WR_ADDR ? 64'(addr_q) :
                        state == WR_RST1 || state == WR_UNHALT || state == WR_GO ? 64'd1 : 64'd0;
  assign mmio_rd_en = state == RD_ADDR || state == POLL_RD;
  assign mmio_rd_addr = state == RD_ADDR ? 16'h0052 : state == POLL_RD ? 16'h0058 : 16'h0000;
endmodule

// File: tb/tb_mmio_launch_sequencer.sv
// tb_mmio_launch_sequencer: event-trace bench comparing two poll-interval variants against a cycle-level launch model
module tb_mmio_launch_sequencer;
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0] kind;
    logic [15:0] addr;
    logic [63:0] data;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n, launch, abort, corrupt, logging;
  logic [63:0] launch_addr;
  logic [31:0] timeout_cycles;
  int done_after, cyc = 0, t0 = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic ev_t ev(input int c, input byte k, input logic [15:0] a, input logic [63:0] d);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.addr = a;
    e.data = d;
    return e;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : inst
    logic busy, complete, timed_out, readback_err, aborted, wr_en, rd_en, pb;
    logic [15:0] wr_addr, rd_addr;
    logic [63:0] wr_data, rd_data, stored;
    logic [102:0] outs;
    int polls = 0;
    ev_t obs[$];
    mmio_launch_sequencer #(.ADDR_WIDTH(64), .TIMEOUT_WIDTH(32), .POLL_INTERVAL(g == 0 ? 16 : 0)) u (
      .clk(clk), .rst_n(rst_n), .launch(launch), .launch_addr(launch_addr),
      .timeout_cycles(timeout_cycles), .abort(abort), .busy(busy), .complete(complete),
      .timed_out(timed_out), .readback_err(readback_err), .aborted(aborted),
      .mmio_wr_en(wr_en), .mmio_wr_addr(wr_addr), .mmio_wr_data(wr_data),
      .mmio_rd_en(rd_en), .mmio_rd_addr(rd_addr), .mmio_rd_data(rd_data));
    assign outs = {busy, complete, timed_out, readback_err, aborted, wr_en, wr_addr, wr_data, rd_en, rd_addr};
    always @(posedge clk) begin
      if (launch && !busy) polls <= 0;
      if (wr_en && wr_addr == 16'h0052) stored <= wr_data;
      if (rd_en) begin
        rd_data <= rd_addr == 16'h0052 ? (corrupt ? 64'h0FFF : stored) :
                   {63'd0, done_after != 0 && polls + 1 >= done_after};
        if (rd_addr == 16'h0058) polls <= polls + 1;
      end
    end
    always @(negedge clk) begin
      if (logging && rst_n) begin
        if (wr_en) obs.push_back(ev(cyc - t0, "W", wr_addr, wr_data));
        if (rd_en) obs.push_back(ev(cyc - t0, "R", rd_addr, 64'h0));
        if (wr_en && rd_en) obs.push_back(ev(cyc - t0, "X", 16'h0, 64'h0));
        if (complete) obs.push_back(ev(cyc - t0, "C", 16'h0, 64'h0));
        if (timed_out) obs.push_back(ev(cyc - t0, "T", 16'h0, 64'h0));
        if (readback_err) obs.push_back(ev(cyc - t0, "E", 16'h0, 64'h0));
        if (aborted) obs.push_back(ev(cyc - t0, "A", 16'h0, 64'h0));
        if (busy && !pb) obs.push_back(ev(cyc - t0, "U", 16'h0, 64'h0));
        if (!busy && pb) obs.push_back(ev(cyc - t0, "B", 16'h0, 64'h0));
      end
      pb <= busy;
    end
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // expected trace from the launch rules: fixed preamble, polls every p cycles, halt then terminal pulse
  task automatic model(input int p, input logic [63:0] ad, input bit bad, input int n, input int t,
                       input int a, input int rs, output ev_t q[$]);
    int h = 0;
    byte pk = "C";
    bit ab = 0;
    q = {};
    q.push_back(ev(1, "W", 16'h0052, ad));
    q.push_back(ev(1, "U", 16'h0, 64'h0));
    q.push_back(ev(2, "R", 16'h0052, 64'h0));
    if (bad) begin
      ab = a >= 1 && a <= 3;
      if (!ab) begin
        q.push_back(ev(4, "E", 16'h0, 64'h0));
        q.push_back(ev(4, "B", 16'h0, 64'h0));
      end
    end else begin
      q.push_back(ev(4, "W", 16'h0054, 64'd1));
      q.push_back(ev(5, "W", 16'h0054, 64'd0));
      q.push_back(ev(6, "W", 16'h0056, 64'd1));
      q.push_back(ev(7, "W", 16'h0050, 64'd1));
      for (int k = 0; k < 100000; k++) begin
        if (a >= 1 && 8 + k * p > a) begin ab = 1; break; end
        q.push_back(ev(8 + k * p, "R", 16'h0058, 64'h0));
        if (n != 0 && k + 1 >= n) begin pk = "C"; h = 10 + k * p; break; end
        if (t != 0 && 1 + k * p >= t) begin pk = "T"; h = 10 + k * p; break; end
      end
      ab = ab || (a >= 1 && a < h);
      if (!ab) begin
        q.push_back(ev(h, "W", 16'h0056, 64'd0));
        q.push_back(ev(h + 1, pk, 16'h0, 64'h0));
        q.push_back(ev(h + 1, "B", 16'h0, 64'h0));
      end
    end
    if (ab) begin
      while (q.size() > 0 && int'(q[$].cyc) > a) void'(q.pop_back());
      q.push_back(ev(a + 1, "W", 16'h0056, 64'd0));
      q.push_back(ev(a + 2, "A", 16'h0, 64'h0));
      q.push_back(ev(a + 2, "B", 16'h0, 64'h0));
    end
    if (rs > 0) while (q.size() > 0 && int'(q[$].cyc) > rs) void'(q.pop_back());
  endtask
  task automatic cmp(input string nm, input ev_t o[$], input ev_t e[$]);
    chk({nm, "_count"}, 128'(o.size()), 128'(e.size()));
    for (int i = 0; i < o.size() && i < e.size(); i++)
      chk($sformatf("%s_ev%0d", nm, i), 128'(o[i]), 128'(e[i]));
  endtask
  task automatic run(input string nm, input logic [63:0] ad, input bit bad, input int n, input int t,
                     input int a, input bit ab_l, input int lb, input int rs);
    int r = 0, idle_for = 0;
    ev_t e0[$], e1[$];
    inst[0].obs.delete();
    inst[1].obs.delete();
    done_after = n;
    corrupt = bad;
    @(negedge clk);
    launch = 1'b1;
    launch_addr = ad;
    timeout_cycles = t;
    abort = ab_l;
    t0 = cyc;
    logging = 1'b1;
    while (idle_for < 3 && r < 12000) begin
      @(negedge clk);
      r = cyc - t0;
      launch = r == lb;
      abort = r == a;
      if (r == rs) begin
        #2 rst_n = 1'b0;
        #1 chk({nm, "_rst_out0"}, 128'(inst[0].outs), 128'h0);
        chk({nm, "_rst_out1"}, 128'(inst[1].outs), 128'h0);
      end
      idle_for = !inst[0].busy && !inst[1].busy ? idle_for + 1 : 0;
    end
    launch = 1'b0;
    abort = 1'b0;
    chk({nm, "_finished"}, 128'(idle_for >= 3), 128'(1));
    if (rs > 0) begin
      @(negedge clk);
      rst_n = 1'b1;
    end
    logging = 1'b0;
    model(18, ad, bad, n, t, a, rs, e0);
    model(2, ad, bad, n, t, a, rs, e1);
    cmp({nm, "_pi16"}, inst[0].obs, e0);
    cmp({nm, "_pi0"}, inst[1].obs, e1);
  endtask
  initial begin
    rst_n = 1'b0;
    launch = 1'b0;
    abort = 1'b0;
    launch_addr = '0;
    timeout_cycles = '0;
    corrupt = 1'b0;
    done_after = 0;
    logging = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out0", 128'(inst[0].outs), 128'h0);
    chk("reset_out1", 128'(inst[1].outs), 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out0", 128'(inst[0].outs), 128'h0);
    chk("idle_out1", 128'(inst[1].outs), 128'h0);
    run("nominal", 64'h1000, 0, 3, 0, -1, 0, 0, 0);
    run("readback", 64'h1000, 1, 3, 0, -1, 0, 0, 0);
    run("timeout", {$urandom, $urandom}, 0, 0, 40, -1, 0, 0, 0);
    run("abort", {$urandom, $urandom}, 0, 0, 0, 30, 0, 0, 0);
    run("launch_abort", {$urandom, $urandom}, 0, 2, 0, -1, 1, 3, 0);
    run("midreset", {$urandom, $urandom}, 0, 2, 0, -1, 0, 0, 6);
    run("restart", {$urandom, $urandom}, 0, 2, 0, -1, 0, 0, 0);
    run("no_timeout", {$urandom, $urandom}, 0, 500, 0, -1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      run($sformatf("rand%0d", i), {$urandom, $urandom} | 64'h0010_0000, $urandom_range(0, 7) == 0,
          int'($urandom_range(1, 4)), $urandom_range(0, 1) == 1 ? int'($urandom_range(1, 60)) : 0,
          $urandom_range(0, 1) == 1 ? int'($urandom_range(1, 60)) : -1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1 ? int'($urandom_range(2, 3)) : 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_launch_sequencer.md
# mmio_launch_sequencer

Host-side MMIO initiator that drives the accelerator's MMIO register map: the write/read side of the `mmio_if` transaction that the AFU memory map responds to. On a single `launch` request it programs the start address, verifies it by readback, pulses the core reset, releases halt, issues go, then polls the done register until completion, timeout or abort. It sits between a test or control harness and the `mmio_if` user port of the memory map. It is used both in simulation and as a synthesizable self-launch path.

## Interface
- `ADDR_WIDTH`, 64: width of the program start address.
- `TIMEOUT_WIDTH`, 32: width of the poll timeout counter.
- `POLL_INTERVAL`, 16: idle cycles between done polls. 0 means back-to-back polls.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `launch` in 1: start request. Sampled only in IDLE.
- `launch_addr` in ADDR_WIDTH: program start address. Latched on accepted `launch`.
- `timeout_cycles` in TIMEOUT_WIDTH: poll timeout. Latched on accepted `launch`. 0 disables the timeout.
- `abort` in 1: cancel the in-progress sequence.
- `busy` out 1: high from the cycle after an accepted `launch` until the terminal pulse.
- `complete` out 1: one-cycle pulse when done is observed and halt has been restored.
- `timed_out` out 1: one-cycle pulse when the sequence ends by timeout.
- `readback_err` out 1: one-cycle pulse when the start-address readback mismatches.
- `aborted` out 1: one-cycle pulse when the sequence ends by abort.
- `mmio_wr_en` out 1, `mmio_wr_addr` out 16, `mmio_wr_data` out 64: MMIO write channel.
- `mmio_rd_en` out 1, `mmio_rd_addr` out 16: MMIO read request.
- `mmio_rd_data` in 64: read data. Valid exactly one cycle after `mmio_rd_en`.

## Operation
- Register map:
  - go: h0050
  - start_addr: h0052
  - reset: h0054
  - unhalt: h0056
  - done: h0058, bit 0
- States and the MMIO action issued in each:
  - IDLE
  - WR_ADDR: write h0052 = zero-extended latched address.
  - RD_ADDR: read h0052.
  - CHK_ADDR: compare `mmio_rd_data[ADDR_WIDTH-1:0]` with the latched address.
    - Mismatch: go to FAIL_RB.
    - Match: go to WR_RST1.
  - WR_RST1: write h0054 = 1.
  - WR_RST0: write h0054 = 0.
  - WR_UNHALT: write h0056 = 1.
  - WR_GO: write h0050 = 1.
  - POLL_RD: read h0058.
  - POLL_CHK: evaluate done and timeout (see below).
  - POLL_WAIT: count POLL_INTERVAL cycles, then go to POLL_RD.
  - HALT: write h0056 = 0, then go to the terminal pulse selected by the cause.
- POLL_CHK evaluation:
  - `mmio_rd_data[0]` = 1: go to HALT, cause complete.
  - Else, `timeout_cycles` != 0 and poll counter >= `timeout_cycles`: go to HALT, cause timeout.
  - Else: go to POLL_WAIT, or directly to POLL_RD when POLL_INTERVAL = 0.
- Poll counter:
  - Cleared on entry to POLL_RD from WR_GO.
  - Increments every cycle while in POLL_RD, POLL_CHK or POLL_WAIT.
  - Saturates at all-ones.
- FAIL_RB pulses `readback_err` and returns to IDLE. No reset, unhalt or go writes are issued.
- `abort` in any non-IDLE state except HALT: go to HALT with cause abort.
  - If a read is outstanding, its data is discarded.
  - `abort` in HALT is ignored.
  - `abort` in IDLE is ignored.
- `launch` while `busy` is ignored and is not queued.
- When `launch` and `abort` are both asserted in IDLE, the launch is accepted.
- Never assert `mmio_wr_en` and `mmio_rd_en` in the same cycle.
- Every access is a single-cycle strobe.
- `mmio_wr_data` upper bits are zero for single-bit registers.

## Timing
- Reset values: state IDLE; all outputs 0, including `mmio_*` address and data; latched registers and counters 0.
- Reset mid-sequence: immediate return to IDLE, no pulse. Any in-flight MMIO strobe drops asynchronously.
- `launch` sampled at cycle 0. Sequence from there:
  - Cycle 1: `busy` rises and the h0052 write is issued.
  - Cycle 2: h0052 read.
  - Cycle 3: compare.
  - Cycles 4–7: writes to h0054=1, h0054=0, h0056=1, h0050=1.
  - Cycle 8: first poll read.
  - Cycle 9: check.
- Done seen on the first poll: HALT write at cycle 10. `complete` pulses and `busy` falls at cycle 11.
- Readback mismatch: `readback_err` pulses and `busy` falls at cycle 4.
- Poll period: 2 + POLL_INTERVAL cycles.
- `abort` sampled in cycle n: HALT write in n+1, `aborted` pulses in n+2.
- All status outputs are registered.

## Test plan
- **Nominal launch.** Stimulus: launch addr h1000, responder reports done on the 3rd poll, POLL_INTERVAL=16. Required: write sequence h0052=h1000, h0054=1, h0054=0, h0056=1, h0050=1; three h0058 reads spaced 18 cycles apart; h0056=0; `complete` pulse at cycle 47.
- **Readback mismatch.** Stimulus: responder returns h0FFF for h0052. Required: `readback_err` pulse at cycle 4; no writes to h0054, h0056 or h0050.
- **Timeout.** Stimulus: `timeout_cycles`=40, done never set. Required: h0056=0 written and `timed_out` pulses; `complete` stays 0; `busy` falls.
- **Abort.** Stimulus: `abort` asserted during the 2nd POLL_WAIT. Required: h0056=0 written next cycle, `aborted` pulse one cycle later, no further h0058 reads.
- **Launch and reset edge cases.**
  - `launch` while busy: ignored, no second write sequence.
  - `launch` with `abort` in IDLE: sequence starts normally.
  - `rst_n` low at cycle 6: all outputs 0 immediately; next `launch` restarts at the h0052 write.
- **Timeout disabled, back-to-back polls.** Stimulus: `timeout_cycles`=0, POLL_INTERVAL=0, done after 1000 cycles. Required: no `timed_out`; polls every 2 cycles; `rd_en` and `wr_en` never high together.
